dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Data-memory access controller directly downstream of the MEM stage.
- Accepts the MEM stage's access request: address, store data, funct3 access type, and read/write strobes.
- Runs it as a valid/ready transaction on the data bus, with byte strobes for stores.
- Returns load data right-aligned to bit 0, so the MEM stage's sign/zero extension on bits [7:0]/[15:0] is correct. Holds the pipeline through `stall` until the access completes.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in RESP waiting for `bus_rsp_valid` before the access is aborted with error.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- mem_read  in  1  load request from MEM stage
- mem_write  in  1  store request from MEM stage
- write_type  in  3  funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- mem_addr  in  32  byte address
- write_data  in  32  store data, right-aligned
- mem_read_data  out  32  load data, right-aligned
- stall  out  1  hold pipeline registers
- access_err  out  1  misaligned / illegal / bus error / timeout, valid in DONE
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {mem_addr[31:2], 2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte enables (0 for reads)
- bus_rsp_valid  in  1  response valid
- bus_rdata  in  32  read word
- bus_rsp_err  in  1  bus error, qualified by bus_rsp_valid

Behaviour:
Reset and clocking:
- Single clock `clk`. `rst_n` is asynchronous, active-low.
- Reset forces: state IDLE; mem_read_data = 0; access_err = 0; bus_req_valid = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0; bus_wstrb = 0; timeout counter = 0.
- Reset mid-transaction abandons it; the bus must tolerate a dropped request.

Stall:
- `stall` is combinational: (mem_read | mem_write) & (state != DONE).
- No request means no stall.

Request capture:
- Taken in IDLE when mem_read | mem_write.
- If both strobes are asserted, the access is treated as a write.

Legality check, performed at capture:
- Halfword access with mem_addr[0] = 1 is illegal.
- Word access with mem_addr[1:0] != 0 is illegal.
- funct3 not listed for the operation is illegal.
- An illegal access issues no bus request: go straight to DONE with access_err = 1 and mem_read_data = 0.

Store formatting, registered at capture:
- SB: wstrb = 0001 << a[1:0]; wdata = {4{wd[7:0]}}.
- SH: wstrb = 0011 << {a[1], 1'b0}; wdata = {2{wd[15:0]}}.
- SW: wstrb = 1111; wdata = wd.

FSM:
- IDLE: on request, legal → REQ with bus outputs loaded; illegal → DONE.
- REQ: bus_req_valid = 1; bus_addr, bus_we, bus_wdata and bus_wstrb held stable until bus_req_ready. On ready → RESP, counter cleared, bus_req_valid = 0 next cycle. bus_rsp_valid in REQ is ignored; the bus never responds in the acceptance cycle.
- RESP: counter increments each cycle.
  - On bus_rsp_valid: mem_read_data = reads ? bus_rdata >> (8·mem_addr[1:0]) : 0; access_err = bus_rsp_err; → DONE.
  - If the counter reaches TIMEOUT_CYCLES - 1 without a response: access_err = 1, mem_read_data = 0, → DONE.
- DONE: lasts exactly 1 cycle with stall = 0, so the pipeline advances on this edge. mem_read_data and access_err are valid. → IDLE; access_err clears on leaving DONE.

Latency and ordering:
- Minimum legal-access latency: capture edge → REQ (1) → RESP (ready in the first REQ cycle) → response in the first RESP cycle → DONE. The result is visible 3 cycles after the request first appears.
- A back-to-back request is captured in the IDLE cycle following DONE.

Test Plan:
- LW @0x100, bus_rdata = 0xDEADBEEF, ready and rsp immediate → stall high for 3 cycles; mem_read_data = 0xDEADBEEF; bus_addr = 0x100; bus_wstrb = 0.
- LB @0x103, bus_rdata = 0x80112233 → mem_read_data = 0x00000080; bus_addr = 0x100.
- SH @0x102, write_data = 0x0000ABCD → bus_we = 1; bus_wstrb = 1100; bus_wdata = 0xABCDABCD; held through 2 cycles of bus_req_ready = 0.
- LW @0x101 → no bus_req_valid; DONE on the next cycle with access_err = 1 and mem_read_data = 0. SH @0x103 gives the same result.
- Read accepted, bus_rsp_valid never asserted → after TIMEOUT_CYCLES in RESP, DONE with access_err = 1; stall drops for one cycle.
- rst_n pulsed low in RESP → all outputs zero immediately; a new request after release proceeds normally from IDLE.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller between the MEM stage and a valid/ready data bus.
// Checks legality, formats store lanes, aligns load data and stalls the pipeline.
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  write_type,
    input  logic [31:0] mem_addr,
    input  logic [31:0] write_data,
    output logic [31:0] mem_read_data,
    output logic        stall,
    output logic        access_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rsp_err
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          req_valid_q, req_valid_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_write_q, is_write_d;
    logic [1:0]    off_q, off_d;

    logic          req;
    logic          legal;
    logic [3:0]    fmt_wstrb;
    logic [31:0]   fmt_wdata;

    assign req   = mem_read | mem_write;
    assign stall = req & (state_q != S_DONE);

    // A simultaneous read and write strobe is handled as a write.
    always_comb begin
        legal = 1'b0;
        if (mem_write) begin
            case (write_type)
                3'b000:  legal = 1'b1;
                3'b001:  legal = ~mem_addr[0];
                3'b010:  legal = (mem_addr[1:0] == 2'b00);
                default: legal = 1'b0;
            endcase
        end else begin
            case (write_type)
                3'b000, 3'b100: legal = 1'b1;
                3'b001, 3'b101: legal = ~mem_addr[0];
                3'b010:         legal = (mem_addr[1:0] == 2'b00);
                default:        legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        fmt_wstrb = 4'b1111;
        fmt_wdata = write_data;
        case (write_type[1:0])
            2'b00: begin
                fmt_wstrb = 4'b0001 << mem_addr[1:0];
                fmt_wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                fmt_wstrb = 4'b0011 << {mem_addr[1], 1'b0};
                fmt_wdata = {2{write_data[15:0]}};
            end
            default: begin
                fmt_wstrb = 4'b1111;
                fmt_wdata = write_data;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
            is_write_q  <= 1'b0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_valid_q <= req_valid_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cnt_q       <= cnt_d;
            is_write_q  <= is_write_d;
            off_q       <= off_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = legal ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus_rsp_valid || (cnt_q == CNT_LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus fields are loaded only at capture so they stay stable for the whole REQ phase.
    always_comb begin
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_valid_d = req_valid_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        off_d       = off_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    is_write_d = mem_write;
                    off_d      = mem_addr[1:0];
                    if (legal) begin
                        req_valid_d = 1'b1;
                        we_d        = mem_write;
                        addr_d      = {mem_addr[31:2], 2'b00};
                        wdata_d     = mem_write ? fmt_wdata : 32'h0;
                        wstrb_d     = mem_write ? fmt_wstrb : 4'b0000;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    req_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + CW'(1);
                if (bus_rsp_valid) begin
                    rdata_d = is_write_q ? 32'h0 : (bus_rdata >> {off_q, 3'b000});
                    err_d   = bus_rsp_err;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
            end
            S_DONE: begin
                err_d = 1'b0;
            end
            default: begin
                err_d = 1'b0;
            end
        endcase
    end

    assign mem_read_data = rdata_q;
    assign access_err    = err_q;
    assign bus_req_valid = req_valid_q;
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;
    assign bus_wstrb     = wstrb_q;

endmodule
